mux_scan_ctrl: RTL and testbench

- Sequencer that sits around the 4:1 case-statement mux.
- Drives the mux `sel` input through every index, waits a settle time, samples the mux `out` bit, and assembles the results into a parallel word.
- Upstream it is the select driver; downstream it is the consumer of the mux output.
- Handshake is start/busy/done, so a host can request one full scan of the mux inputs.

---
 rtl/mux_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan sequencer for a 2**SEL_W:1 mux.
// Drives every select index, waits SETTLE cycles, samples the mux output and
// assembles the results into a parallel word. The host uses a start/busy/done handshake.
//
// Optional feature: define MUX_SCAN_AUTO_EN to add the auto_run input. When auto_run
// is high in DONE, a new scan starts back-to-back and busy stays high.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         scan request, sampled only in IDLE
//   auto_run      (MUX_SCAN_AUTO_EN only) restart a scan directly from DONE
//   mux_out       mux output bit, assumed settled
//   sel           select driven to the mux
//   busy          high from the first DRIVE cycle through the DONE cycle
//   sample_valid  one-cycle pulse in each SAMPLE cycle
//   sample_idx    index being sampled (equals sel while sample_valid)
//   data_out      last completed scan, bit i = mux_out with sel = i
//   done          one-cycle pulse in the DONE cycle
module mux_scan_ctrl #(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
`ifdef MUX_SCAN_AUTO_EN
  input  logic                    auto_run,
`endif
  input  logic                    mux_out,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    sample_valid,
  output logic [SEL_W-1:0]        sample_idx,
  output logic [(2**SEL_W)-1:0]   data_out,
  output logic                    done
);

  localparam int unsigned NIn = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] IdxLast = SEL_W'(NIn - 1);
  localparam logic [3:0]       CntLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NIn-1:0]   shadow_q, shadow_d;
  logic [NIn-1:0]   data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] sidx_q, sidx_d;
  logic             busy_q, busy_d;
  logic             sv_q, sv_d;
  logic             done_q, done_d;
  logic             restart;

`ifdef MUX_SCAN_AUTO_EN
  assign restart = auto_run;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrive;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) state_d = StSample;
      end
      StSample: begin
        shadow_d[idx_q] = mux_out;
        if (idx_q == IdxLast) begin
          state_d = StDone;
          // Load on the edge into DONE so data_out is already valid while done is high.
          data_d  = shadow_d;
        end else begin
          state_d = StDrive;
          idx_d   = idx_q + SEL_W'(1);
          cnt_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (restart) begin
          state_d = StDrive;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered: derive their next values from the next state.
    busy_d = (state_d != StIdle);
    sv_d   = (state_d == StSample);
    done_d = (state_d == StDone);
    sel_d  = ((state_d == StDrive) || (state_d == StSample)) ? idx_d : sel_q;
    sidx_d = (state_d == StSample) ? idx_d : sidx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      sidx_q   <= '0;
      busy_q   <= 1'b0;
      sv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      sidx_q   <= sidx_d;
      busy_q   <= busy_d;
      sv_q     <= sv_d;
      done_q   <= done_d;
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign sample_idx   = sidx_q;
  assign data_out     = data_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: default instance (SETTLE = 1) and a SETTLE = 3 instance.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [3:0] a0, a1;
  logic       mo0, mo1;
  logic [1:0] sel0, sel1, sidx0, sidx1;
  logic       busy0, busy1, sv0, sv1, done0, done1;
  logic [3:0] data0, data1;
`ifdef MUX_SCAN_AUTO_EN
  logic       auto0, auto1;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural 4:1 mux in front of each sequencer.
  assign mo0 = a0[sel0];
  assign mo1 = a1[sel1];

  mux_scan_ctrl #(.SEL_W(2), .SETTLE(1)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start0),
`ifdef MUX_SCAN_AUTO_EN
    .auto_run     (auto0),
`endif
    .mux_out      (mo0),
    .sel          (sel0),
    .busy         (busy0),
    .sample_valid (sv0),
    .sample_idx   (sidx0),
    .data_out     (data0),
    .done         (done0)
  );

  mux_scan_ctrl #(.SEL_W(2), .SETTLE(3)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start1),
`ifdef MUX_SCAN_AUTO_EN
    .auto_run     (auto1),
`endif
    .mux_out      (mo1),
    .sel          (sel1),
    .busy         (busy1),
    .sample_valid (sv1),
    .sample_idx   (sidx1),
    .data_out     (data1),
    .done         (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full scan on dut0. Start is raised for one cycle or held through the scan.
  task automatic scan0(input string name, input logic [3:0] exp_data,
                       input logic [3:0] prev_data, input logic hold_start);
    start0 = 1'b1;
    tick();
    if (!hold_start) start0 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("%s busy c%0d", name, k), busy0, 1);
      if (k < 9) begin
        chk($sformatf("%s sel c%0d", name, k), sel0, (k - 1) / 2);
        chk($sformatf("%s sv c%0d", name, k), sv0, (k % 2 == 0));
        if (k % 2 == 0) chk($sformatf("%s sidx c%0d", name, k), sidx0, (k - 1) / 2);
        chk($sformatf("%s done c%0d", name, k), done0, 0);
        chk($sformatf("%s data hold c%0d", name, k), data0, prev_data);
        tick();
      end else begin
        chk($sformatf("%s done c9", name), done0, 1);
        chk($sformatf("%s data c9", name), data0, exp_data);
        start0 = 1'b0;
      end
    end
    tick();
    chk({name, " busy after"}, busy0, 0);
    chk({name, " done after"}, done0, 0);
    chk({name, " sel holds"}, sel0, 3);
    tick();
    chk({name, " no restart"}, busy0, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    a0     = 4'b1100;
    a1     = 4'b1001;
`ifdef MUX_SCAN_AUTO_EN
    auto0  = 1'b0;
    auto1  = 1'b0;
`endif

    // Reset values.
    tick(); tick(); tick();
    chk("rst sel", sel0, 0);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    chk("rst sv", sv0, 0);
    chk("rst data", data0, 4'b0000);
    chk("rst data settle3", data1, 4'b0000);
    rst_n = 1'b1;
    tick();

    // Basic scan.
    scan0("basic", 4'b1100, 4'b0000, 1'b0);

    // Start held high for a whole scan: exactly one scan.
    scan0("held", 4'b1100, 4'b1100, 1'b1);
    a0 = 4'b0101;
    scan0("rescan", 4'b0101, 4'b1100, 1'b0);

    // Asynchronous reset in the middle of a scan.
    a0 = 4'b1111;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst sel", sel0, 0);
    chk("midrst busy", busy0, 0);
    chk("midrst sv", sv0, 0);
    chk("midrst sidx", sidx0, 0);
    chk("midrst data", data0, 4'b0000);
    chk("midrst done", done0, 0);
    tick();
    chk("midrst done held", done0, 0);
    rst_n = 1'b1;
    tick();
    scan0("postrst", 4'b1111, 4'b0000, 1'b0);

    // SETTLE = 3 instance.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("s3 busy c%0d", k), busy1, 1);
      if (k < 17) begin
        chk($sformatf("s3 sel c%0d", k), sel1, (k - 1) / 4);
        chk($sformatf("s3 sv c%0d", k), sv1, (k % 4 == 0));
        chk($sformatf("s3 done c%0d", k), done1, 0);
        tick();
      end else begin
        chk("s3 done c17", done1, 1);
        chk("s3 data c17", data1, 4'b1001);
      end
    end
    tick();
    chk("s3 busy after", busy1, 0);

`ifdef MUX_SCAN_AUTO_EN
    // Back-to-back scans, then drop auto_run before the second DONE.
    a0 = 4'b1100;
    auto0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      chk($sformatf("auto busy c%0d", k), busy0, 1);
      chk($sformatf("auto done c%0d", k), done0, ((k == 9) || (k == 18)));
      if ((k == 9) || (k == 18)) chk($sformatf("auto data c%0d", k), data0, 4'b1100);
      if (k == 10) auto0 = 1'b0;
      if (k < 18) tick();
    end
    tick();
    chk("auto busy after", busy0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
